// File: rtl/cpu_seg_display_if.sv
// CPU debug bus into the seven-segment output stage, plus the display/LED
// outputs coming back. master = board/CPU side, slave = display stage.
interface cpu_seg_display_if;
  logic        snap;
  logic        btn_page;
  logic [31:0] PCRes;
  logic [31:0] SeletePCRes;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] ReadRes1;
  logic [31:0] ReadRes2;
  logic [31:0] ALURes;
  logic [31:0] DataMemRes;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  page;

  modport master (
    output snap, btn_page, PCRes, SeletePCRes, rs, rt,
           ReadRes1, ReadRes2, ALURes, DataMemRes,
    input  an, seg, page
  );

  modport slave (
    input  snap, btn_page, PCRes, SeletePCRes, rs, rt,
           ReadRes1, ReadRes2, ALURes, DataMemRes,
    output an, seg, page
  );
endinterface

// File: rtl/cpu_seg_display.sv
// 4-digit seven-segment viewer for multi-cycle CPU debug values: snapshot, page select, scan.
// Optional page-button debounce filter enabled by defining SEG_DEBOUNCE_EN.

// Active-low hex glyph for one digit position; DP_LIT lights the decimal point.
module seg_digit #(
  parameter bit DP_LIT = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] glyph
);
  logic [7:0] raw;

  always_comb begin
    raw = 8'hFF;
    case (nib)
      4'h0: raw = 8'hC0;
      4'h1: raw = 8'hF9;
      4'h2: raw = 8'hA4;
      4'h3: raw = 8'hB0;
      4'h4: raw = 8'h99;
      4'h5: raw = 8'h92;
      4'h6: raw = 8'h82;
      4'h7: raw = 8'hF8;
      4'h8: raw = 8'h80;
      4'h9: raw = 8'h90;
      4'hA: raw = 8'h88;
      4'hB: raw = 8'h83;
      4'hC: raw = 8'hC6;
      4'hD: raw = 8'hA1;
      4'hE: raw = 8'h86;
      4'hF: raw = 8'h8E;
      default: raw = 8'hFF;
    endcase
  end

  assign glyph = DP_LIT ? (raw & 8'h7F) : raw;
endmodule

module cpu_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEB_CYCLES  = 500000
) (
  input logic              CLK,
  input logic              RST,
  cpu_seg_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [3:0][15:0] snap_q;
  logic [1:0]       page_q;
  logic [15:0]      word;
  logic [3:0][7:0]  glyph;
  logic [CW-1:0]    rcnt;
  logic             wrap;
  logic             render;
  logic [1:0]       idx;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;
  logic [1:0]       sync;
  logic             filt;
  logic             filt_q;
  logic             unused_bits;

  // Snapshot of the four 16-bit pages
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_q <= '0;
    end else if (bus.snap) begin
      snap_q[0] <= {bus.PCRes[7:0], bus.SeletePCRes[7:0]};
      snap_q[1] <= {3'b000, bus.rs, bus.ReadRes1[7:0]};
      snap_q[2] <= {3'b000, bus.rt, bus.ReadRes2[7:0]};
      snap_q[3] <= {bus.ALURes[7:0], bus.DataMemRes[7:0]};
    end
  end

  assign word = snap_q[page_q];

  for (genvar k = 0; k < 4; k++) begin : g_dig
    seg_digit #(.DP_LIT(k == 2)) u_dig (
      .nib   (word[4*k +: 4]),
      .glyph (glyph[k])
    );
  end

  // Digits are only rendered the cycle after a divider wrap, so page or
  // snapshot changes never disturb the slot currently on the glass.
  assign wrap = (rcnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt   <= '0;
      render <= 1'b0;
      idx    <= 2'd0;
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      rcnt   <= wrap ? '0 : rcnt + 1'b1;
      render <= wrap;
      if (render) begin
        an_q  <= ~(4'b0001 << idx);
        seg_q <= glyph[idx];
        idx   <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= 2'b00;
    else     sync <= {sync[0], bus.btn_page};
  end

`ifdef SEG_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] dcnt;

  // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt <= 1'b0;
      dcnt <= '0;
    end else if (sync[1] == filt) begin
      dcnt <= '0;
    end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
      filt <= sync[1];
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  assign unused_bits = ^{bus.PCRes[31:8], bus.SeletePCRes[31:8], bus.ReadRes1[31:8],
                         bus.ReadRes2[31:8], bus.ALURes[31:8], bus.DataMemRes[31:8]};
`else
  assign filt = sync[1];

  assign unused_bits = ^{bus.PCRes[31:8], bus.SeletePCRes[31:8], bus.ReadRes1[31:8],
                         bus.ReadRes2[31:8], bus.ALURes[31:8], bus.DataMemRes[31:8],
                         DEB_CYCLES[0]};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_q <= 1'b0;
      page_q <= 2'd0;
    end else begin
      filt_q <= filt;
      if (filt && !filt_q) page_q <= page_q + 1'b1;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.page = page_q;
endmodule

// File: tb/tb_cpu_seg_display.sv
// Bench for cpu_seg_display (REFRESH_DIV=4, DEB_CYCLES=8): directed steps plus random
// snapshots/page presses checked against a spec-level display model.
module tb_cpu_seg_display;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  cpu_seg_display_if bus();

  cpu_seg_display #(.REFRESH_DIV(4), .DEB_CYCLES(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [15:0] m_snap [4];
  logic [1:0]  m_page;

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d, input logic [15:0] w);
    logic [7:0] g;
    g = hex_glyph(4'((w >> (4 * d)) & 16'hF));
    if (d == 2) g = g & 8'h7F;
    return g;
  endfunction

  function automatic logic [3:0] exp_an(input int d);
    return ~(4'(1 << d));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  // Async reset asserted mid-cycle, then released; first digit expected 5 cycles later
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_an",   16'(bus.an),   16'hF);
    chk("rst_seg",  16'(bus.seg),  16'hFF);
    chk("rst_page", 16'(bus.page), 16'h0);
    bus.btn_page = 1'b0;
    bus.snap     = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST    = 1'b0;
    cyc    = 0;
    m_page = 2'd0;
    for (int i = 0; i < 4; i++) m_snap[i] = 16'h0;
    tick(4);
    chk("post_rst_blank", 16'(bus.an), 16'hF);
    tick(1);
    chk("post_rst_first", 16'(bus.an), 16'hE);
  endtask

  task automatic set_cpu(input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] alu, input logic [31:0] dm);
    bus.PCRes = pc; bus.SeletePCRes = npc; bus.rs = rs; bus.rt = rt;
    bus.ReadRes1 = r1; bus.ReadRes2 = r2; bus.ALURes = alu; bus.DataMemRes = dm;
  endtask

  task automatic model_capture();
    m_snap[0] = {bus.PCRes[7:0], bus.SeletePCRes[7:0]};
    m_snap[1] = {3'b000, bus.rs, bus.ReadRes1[7:0]};
    m_snap[2] = {3'b000, bus.rt, bus.ReadRes2[7:0]};
    m_snap[3] = {bus.ALURes[7:0], bus.DataMemRes[7:0]};
  endtask

  task automatic pulse_snap();
    bus.snap = 1'b1;
    model_capture();
    tick(1);
    bus.snap = 1'b0;
  endtask

  // One clean press; page advances a fixed latency after the raw rising edge
  task automatic press();
    logic [1:0] nxt;
    nxt = m_page + 2'd1;
    bus.btn_page = 1'b1;
`ifdef SEG_DEBOUNCE_EN
    tick(12);
    m_page = nxt;
    chk("press_page", 16'(bus.page), 16'(m_page));
    bus.btn_page = 1'b0;
    tick(14);
`else
    tick(2);
    chk("press_early", 16'(bus.page), 16'(m_page));
    tick(1);
    m_page = nxt;
    chk("press_page", 16'(bus.page), 16'(m_page));
    bus.btn_page = 1'b0;
    tick(3);
`endif
    chk("press_hold", 16'(bus.page), 16'(m_page));
  endtask

  // Four full slots from the next slot boundary: each digit in turn, held for 4 cycles
  task automatic check_scan(input string tag);
    int d;
    tick(1);
    while (cyc < 5 || ((cyc - 5) % 4) != 0) tick(1);
    for (int s = 0; s < 4; s++) begin
      d = ((cyc - 5) / 4) % 4;
      chk({tag, "_an"},   16'(bus.an),   16'(exp_an(d)));
      chk({tag, "_seg"},  16'(bus.seg),  16'(exp_seg(d, m_snap[m_page])));
      chk({tag, "_page"}, 16'(bus.page), 16'(m_page));
      for (int j = 1; j < 4; j++) begin
        tick(1);
        chk({tag, "_slot_an"},  16'(bus.an),  16'(exp_an(d)));
        chk({tag, "_slot_seg"}, 16'(bus.seg), 16'(exp_seg(d, m_snap[m_page])));
      end
      tick(1);
    end
  endtask

  initial begin
    bus.snap = 1'b0;
    bus.btn_page = 1'b0;
    set_cpu('0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge CLK);
    do_reset();

    // Scan of W=16'h1418 on page 0
    set_cpu(32'h14, 32'h18, 5'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    pulse_snap();
    check_scan("scan");

    // Page 1 shows {rs, ReadRes1} = 1,F,0,7, then wrap the page counter
    set_cpu(32'h14, 32'h18, 5'h1F, 5'h3, 32'h7, 32'h55, 32'h12, 32'h34);
    pulse_snap();
    press();
    check_scan("page1");
    press();
    press();
    press();
    chk("page_wrap", 16'(bus.page), 16'h0);

    // Snapshot hold on page 3, then capture A/b
    while (m_page != 2'd3) press();
    check_scan("p3_before");
    bus.ALURes = 32'hAB;
    tick(1);
    check_scan("p3_hold");
    pulse_snap();
    check_scan("p3_new");

    // Short glitch on the button
    bus.btn_page = 1'b1;
`ifdef SEG_DEBOUNCE_EN
    tick(5);
    bus.btn_page = 1'b0;
    tick(14);
    chk("glitch_page", 16'(bus.page), 16'(m_page));
    press();
`else
    tick(3);
    m_page = m_page + 2'd1;
    chk("glitch_page", 16'(bus.page), 16'(m_page));
    tick(2);
    bus.btn_page = 1'b0;
    tick(3);
    chk("glitch_hold", 16'(bus.page), 16'(m_page));
`endif

    // Snap and page step landing on the same clock edge
`ifdef SEG_DEBOUNCE_EN
    press();
    set_cpu(32'hC3, 32'h5A, 5'h0A, 5'h15, 32'hE1, 32'h2D, 32'h9F, 32'h60);
    pulse_snap();
`else
    bus.btn_page = 1'b1;
    tick(2);
    set_cpu(32'hC3, 32'h5A, 5'h0A, 5'h15, 32'hE1, 32'h2D, 32'h9F, 32'h60);
    m_page = m_page + 2'd1;
    pulse_snap();
    chk("simul_page", 16'(bus.page), 16'(m_page));
    bus.btn_page = 1'b0;
    tick(3);
`endif
    check_scan("simul");

    // Random snapshots and page presses
    for (int it = 0; it < 8; it++) begin
      int np;
      set_cpu($urandom, $urandom, 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) != 0) pulse_snap();
      else tick(1);
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) press();
      check_scan("rand");
    end

    // Reset in the middle of scanning
    tick(2);
    do_reset();
    check_scan("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
